// File: rtl/aes_stream_adapter_if.sv
// Stream side of the AES adapter: a 32-bit input word stream (key or plaintext)
// and a 32-bit ciphertext output stream, both valid/ready handshaked.
interface aes_stream_adapter_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_is_key;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    // Producer/consumer side (testbench or upstream/downstream logic)
    modport master (
        output s_valid, s_data, s_is_key, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // Adapter side
    modport slave (
        input  s_valid, s_data, s_is_key, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/aes_stream_adapter.sv
// Packs 32-bit key/plaintext words into 128-bit registers for an AES_top core,
// runs the core with a completion timeout, and streams the 128-bit result back
// out as four 32-bit words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting key/data words; leaves once 4 key + 4 data words held
// RUN   | aes_en high, waiting for aes_dout_valid or timeout
// OUT   | streaming the captured result, one word per m handshake
module aes_stream_adapter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       AES_clk,
    input  logic                       AES_rst,
    aes_stream_adapter_if.slave        strm,
    output logic                       aes_en,
    output logic [127:0]               aes_data,
    output logic [127:0]               aes_key,
    input  logic [127:0]               aes_dout,
    input  logic                       aes_dout_valid,
    output logic                       busy,
    output logic                       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] result_q, result_d;
    logic [2:0]   key_cnt_q, key_cnt_d;
    logic [2:0]   data_cnt_q, data_cnt_d;
    logic [7:0]   run_cnt_q, run_cnt_d;
    logic [1:0]   word_idx_q, word_idx_d;
    logic         aes_en_q, aes_en_d;
    logic         err_q, err_d;
    logic         s_fire;
    logic         m_fire;
    logic [31:0]  m_word;

    assign s_fire = strm.s_valid && strm.s_ready;
    assign m_fire = (state_q == ST_OUT) && strm.m_ready;

    // Next-state, packing and result capture
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        data_d     = data_q;
        result_d   = result_q;
        key_cnt_d  = key_cnt_q;
        data_cnt_d = data_cnt_q;
        run_cnt_d  = run_cnt_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    if (strm.s_is_key) begin
                        key_d = {key_q[95:0], strm.s_data};
                        // A fifth key word begins a fresh key rather than sliding
                        key_cnt_d = (key_cnt_q == 3'd4) ? 3'd1 : key_cnt_q + 3'd1;
                    end else begin
                        data_d = {data_q[95:0], strm.s_data};
                        // Data saturates at 4 so the window keeps the latest four
                        data_cnt_d = (data_cnt_q == 3'd4) ? 3'd4 : data_cnt_q + 3'd1;
                    end
                end
                // Decide on the counts as they land at this edge so RUN follows
                // the completing word by exactly one cycle
                if ((key_cnt_d == 3'd4) && (data_cnt_d == 3'd4)) begin
                    state_d   = ST_RUN;
                    run_cnt_d = 8'd0;
                end
            end
            ST_RUN: begin
                if (aes_dout_valid) begin
                    result_d   = aes_dout;
                    word_idx_d = 2'd0;
                    state_d    = ST_OUT;
                end else if (run_cnt_q == RUN_LAST) begin
                    err_d      = 1'b1;
                    data_cnt_d = 3'd0;
                    state_d    = ST_IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + 8'd1;
                end
            end
            ST_OUT: begin
                if (m_fire) begin
                    if (word_idx_q == 2'd3) begin
                        data_cnt_d = 3'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        word_idx_d = word_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        aes_en_d = (state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            data_q     <= '0;
            result_q   <= '0;
            key_cnt_q  <= '0;
            data_cnt_q <= '0;
            run_cnt_q  <= '0;
            word_idx_q <= '0;
            aes_en_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            data_q     <= data_d;
            result_q   <= result_d;
            key_cnt_q  <= key_cnt_d;
            data_cnt_q <= data_cnt_d;
            run_cnt_q  <= run_cnt_d;
            word_idx_q <= word_idx_d;
            aes_en_q   <= aes_en_d;
            err_q      <= err_d;
        end
    end

    // Output word select, most significant word first
    always_comb begin
        m_word = result_q[127:96];
        case (word_idx_q)
            2'd0: m_word = result_q[127:96];
            2'd1: m_word = result_q[95:64];
            2'd2: m_word = result_q[63:32];
            2'd3: m_word = result_q[31:0];
        endcase
    end

    assign strm.s_ready = (state_q == ST_IDLE) && !AES_rst;
    assign strm.m_valid = (state_q == ST_OUT);
    assign strm.m_data  = m_word;
    assign strm.m_last  = (state_q == ST_OUT) && (word_idx_q == 2'd3);

    assign aes_en   = aes_en_q;
    assign aes_data = data_q;
    assign aes_key  = key_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter: a table of block transactions plus
// hand-written reset-mid-RUN and data-before-key sequences. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_aes_stream_adapter;
    localparam int TIMEOUT = 64;

    logic         AES_clk = 1'b0;
    logic         AES_rst;
    logic         aes_en;
    logic [127:0] aes_data;
    logic [127:0] aes_key;
    logic [127:0] aes_dout;
    logic         aes_dout_valid;
    logic         busy;
    logic         err;

    aes_stream_adapter_if bus ();

    aes_stream_adapter #(.TIMEOUT(TIMEOUT)) dut (
        .AES_clk        (AES_clk),
        .AES_rst        (AES_rst),
        .strm           (bus),
        .aes_en         (aes_en),
        .aes_data       (aes_data),
        .aes_key        (aes_key),
        .aes_dout       (aes_dout),
        .aes_dout_valid (aes_dout_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 AES_clk = ~AES_clk;

    typedef struct {
        string        name;
        bit           new_key;
        logic [127:0] kwords;    // first key word in [127:96]
        int           ndata;
        logic [159:0] dwords;    // first data word in [159:128]
        logic [127:0] exp_key;
        logic [127:0] exp_data;
        logic [127:0] dout;
        int           delay;     // aes_en cycles before core answers; -1 = never
        bit           bp;
        bit           exp_err;
    } vec_t;

    vec_t vecs [5];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_word(input logic is_key, input logic [31:0] w);
        int n = 0;
        bus.s_valid  = 1'b1;
        bus.s_data   = w;
        bus.s_is_key = is_key;
        while (bus.s_ready !== 1'b1 && n < 100) begin
            @(negedge AES_clk);
            n++;
        end
        chk("s_ready_wait", bus.s_ready, 1'b1);
        @(negedge AES_clk);
        bus.s_valid = 1'b0;
    endtask

    // Entered on the first aes_en cycle; models the core and drains the output.
    task automatic core_and_collect(input string name, input int delay, input logic [127:0] dout,
                                    input bit bp, input bit exp_err,
                                    input logic [127:0] exp_key, input logic [127:0] exp_data);
        int en_cnt = 0;
        bit m_seen = 1'b0;
        int n;
        logic [31:0] w;
        while (aes_en === 1'b1 && en_cnt < 300) begin
            if (bus.m_valid === 1'b1) m_seen = 1'b1;
            aes_dout       = dout;
            aes_dout_valid = (en_cnt == delay);
            en_cnt++;
            @(negedge AES_clk);
            bus.s_valid = 1'b0;
        end
        aes_dout_valid = 1'b0;
        chk({name, ".aes_en_cycles"}, en_cnt, (delay < 0) ? TIMEOUT : delay + 1);
        chk({name, ".aes_key_hold"}, aes_key, exp_key);
        chk({name, ".aes_data_hold"}, aes_data, exp_data);
        if (delay < 0) begin
            repeat (3) begin
                if (bus.m_valid === 1'b1) m_seen = 1'b1;
                @(negedge AES_clk);
            end
            chk({name, ".no_m_valid"}, m_seen, 1'b0);
            chk({name, ".busy_after_to"}, busy, 1'b0);
            chk({name, ".err"}, err, 1'b1);
        end else begin
            chk({name, ".m_valid_rise"}, bus.m_valid, 1'b1);
            chk({name, ".aes_en_in_out"}, aes_en, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n = 0;
                while (bus.m_valid !== 1'b1 && n < 50) begin
                    @(negedge AES_clk);
                    n++;
                end
                w = dout[127 - 32*i -: 32];
                chk({name, ".m_data"}, bus.m_data, w);
                chk({name, ".m_last"}, bus.m_last, (i == 3));
                if (bp && i == 1) begin
                    bus.m_ready = 1'b0;
                    repeat (5) begin
                        @(negedge AES_clk);
                        chk({name, ".bp_hold_data"}, bus.m_data, w);
                        chk({name, ".bp_hold_valid"}, bus.m_valid, 1'b1);
                    end
                end
                bus.m_ready = 1'b1;
                @(negedge AES_clk);
                bus.m_ready = 1'b0;
            end
            chk({name, ".m_valid_drop"}, bus.m_valid, 1'b0);
            chk({name, ".busy_idle"}, busy, 1'b0);
            chk({name, ".s_ready_idle"}, bus.s_ready, 1'b1);
            chk({name, ".err"}, err, exp_err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (v.new_key)
            for (int i = 0; i < 4; i++) send_word(1'b1, v.kwords[127 - 32*i -: 32]);
        for (int i = 0; i < 4; i++) send_word(1'b0, v.dwords[159 - 32*i -: 32]);
        chk({v.name, ".aes_en_latency"}, aes_en, 1'b1);
        chk({v.name, ".busy_run"}, busy, 1'b1);
        chk({v.name, ".s_ready_run"}, bus.s_ready, 1'b0);
        chk({v.name, ".aes_key"}, aes_key, v.exp_key);
        chk({v.name, ".aes_data"}, aes_data, v.exp_data);
        if (v.ndata == 5) begin
            bus.s_valid  = 1'b1;
            bus.s_data   = v.dwords[31:0];
            bus.s_is_key = 1'b0;
        end
        core_and_collect(v.name, v.delay, v.dout, v.bp, v.exp_err, v.exp_key, v.exp_data);
    endtask

    initial begin
        bit busy_seen;
        bit m_seen;

        vecs[0] = '{"basic", 1'b1, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, 4,
                    160'h0000004b_00000000_00000000_00000000_00000000,
                    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                    128'h0000004b_00000000_00000000_00000000,
                    128'h01234567_89abcdef_fedcba98_76543210, 12, 1'b0, 1'b0};
        vecs[1] = '{"slide", 1'b0, 128'h0, 5,
                    160'ha6f2daeb_140fa720_529e75d5_21cbc681_d7b26248,
                    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                    128'ha6f2daeb_140fa720_529e75d5_21cbc681,
                    128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97, 5, 1'b0, 1'b0};
        vecs[2] = '{"backpr", 1'b0, 128'h0, 4,
                    160'h00000001_00000002_00000003_00000004_00000000,
                    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                    128'h00000001_00000002_00000003_00000004,
                    128'h01234567_89abcdef_fedcba98_76543210, 0, 1'b1, 1'b0};
        vecs[3] = '{"timeout", 1'b0, 128'h0, 4,
                    160'hdeadbeef_cafef00d_01020304_05060708_00000000,
                    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                    128'hdeadbeef_cafef00d_01020304_05060708,
                    128'h0, -1, 1'b0, 1'b1};
        vecs[4] = '{"lastcyc", 1'b1, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4,
                    160'h6bc1bee2_2e409f96_e93d7e11_7393172a_00000000,
                    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                    128'h6bc1bee2_2e409f96_e93d7e11_7393172a,
                    128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97, TIMEOUT - 1, 1'b0, 1'b1};

        AES_rst        = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_is_key   = 1'b0;
        bus.m_ready    = 1'b0;
        aes_dout       = '0;
        aes_dout_valid = 1'b0;
        repeat (3) @(negedge AES_clk);
        chk("rst.s_ready", bus.s_ready, 1'b0);
        AES_rst = 1'b0;
        @(negedge AES_clk);
        chk("rst.aes_en", aes_en, 1'b0);
        chk("rst.aes_data", aes_data, 128'h0);
        chk("rst.aes_key", aes_key, 128'h0);
        chk("rst.m_valid", bus.m_valid, 1'b0);
        chk("rst.m_data", bus.m_data, 32'h0);
        chk("rst.m_last", bus.m_last, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.s_ready_after", bus.s_ready, 1'b1);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Reset in the 5th RUN cycle; key from "lastcyc" is still loaded
        for (int i = 0; i < 4; i++) send_word(1'b0, 32'h0000_0a00 + 32'(i));
        chk("midrst.run", aes_en, 1'b1);
        repeat (4) @(negedge AES_clk);
        AES_rst = 1'b1;
        #1;
        chk("midrst.s_ready_in_rst", bus.s_ready, 1'b0);
        @(negedge AES_clk);
        AES_rst = 1'b0;
        chk("midrst.aes_en", aes_en, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.err_cleared", err, 1'b0);
        chk("midrst.aes_key", aes_key, 128'h0);
        aes_dout       = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
        aes_dout_valid = 1'b1;
        m_seen         = 1'b0;
        busy_seen      = 1'b0;
        repeat (2) @(negedge AES_clk);
        aes_dout_valid = 1'b0;
        repeat (3) begin
            if (bus.m_valid === 1'b1) m_seen = 1'b1;
            if (busy === 1'b1) busy_seen = 1'b1;
            @(negedge AES_clk);
        end
        chk("midrst.late_valid_ignored", m_seen, 1'b0);
        chk("midrst.stay_idle", busy_seen, 1'b0);

        // Data before key: key_cnt was cleared, so five data words never start RUN
        busy_seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_word(1'b0, {8{4'(i)}});
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        chk("dfirst.no_run_without_key", busy_seen, 1'b0);
        send_word(1'b1, 32'haa2bdb40);
        send_word(1'b1, 32'hbff6a5e8);
        send_word(1'b1, 32'hcaa9ba3e);
        send_word(1'b1, 32'hbc1e2acc);
        chk("dfirst.aes_en_latency", aes_en, 1'b1);
        chk("dfirst.aes_data", aes_data, 128'h22222222_33333333_44444444_55555555);
        chk("dfirst.aes_key", aes_key, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        core_and_collect("dfirst", 3, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b0,
                         128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                         128'h22222222_33333333_44444444_55555555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 Parameter: TIMEOUT, default 64, range 2..255 -- maximum RUN cycles allowed while waiting for core completion.
REQ-002 AES_clk  in  1  -- single clock; all logic rising-edge.
REQ-003 AES_rst  in  1  -- reset, synchronous, active-high.
REQ-004 s_valid  in  1  -- input word valid.
REQ-005 s_ready  out  1  -- input word accepted when s_valid && s_ready.
REQ-006 s_data  in  32  -- input word.
REQ-007 s_is_key  in  1  -- 1: word is key material; 0: word is plaintext.
REQ-008 aes_en  out  1  -- drives AES_en of the downstream AES_top core.
REQ-009 aes_data  out  128  -- drives AES_data_in.
REQ-010 aes_key  out  128  -- drives AES_key_in.
REQ-011 aes_dout  in  128  -- from AES_data_out.
REQ-012 aes_dout_valid  in  1  -- from AES_data_out_valid.
REQ-013 m_valid  out  1  -- output word valid.
REQ-014 m_ready  in  1  -- output word consumed when m_valid && m_ready.
REQ-015 m_data  out  32  -- output ciphertext word.
REQ-016 m_last  out  1  -- marks the 4th word of a block.
REQ-017 busy  out  1  -- high in RUN or OUT.
REQ-018 err  out  1  -- sticky timeout flag.

Function
REQ-019 FSM states: IDLE, RUN, OUT; s_ready = (state==IDLE) && !AES_rst.
REQ-020 Word packing: reg <= {reg[95:0], word}; the first accepted word ends in [127:96].
REQ-021 Key word accepted: shift into key reg; key_cnt++ saturating at 4. If key_cnt==4 already: key_cnt=1, and this word starts a new key.
REQ-022 Data word accepted: shift into data reg; data_cnt++ saturating at 4. When data_cnt==4, the window slides and holds the latest 4 words.
REQ-023 Key persists across blocks; data_cnt clears to 0 on every return to IDLE.
REQ-024 IDLE->RUN at the first clock edge where data_cnt==4 && key_cnt==4 (registered counts).
- The 4th word accepted in cycle N gives RUN and aes_en=1 in cycle N+1.
REQ-025 aes_data/aes_key are the packing registers; they shall not change while in RUN or OUT.
REQ-026 aes_en is registered and is 1 exactly while state==RUN.
REQ-027 In RUN, aes_dout_valid=1 in cycle M: capture aes_dout into result register; cycle M+1 is OUT with aes_en=0 and m_valid=1.
REQ-028 aes_dout_valid outside RUN shall be ignored.
REQ-029 RUN cycle counter starts at 0 on entry. If TIMEOUT RUN cycles elapse with no aes_dout_valid: err=1, go to IDLE, data_cnt=0, no output words.
- aes_dout_valid in the final allowed cycle counts as success.
REQ-030 OUT: m_valid=1; m_data = result[127:96], [95:64], [63:32], [31:0] in order, advancing one word per handshake; m_last=1 on the 4th word only.
REQ-031 m_data/m_last shall hold stable while m_valid && !m_ready.
REQ-032 On the 4th OUT handshake: go to IDLE, m_valid=0 the next cycle.
REQ-033 Back-to-back blocks: new data words may be accepted from the first IDLE cycle.
REQ-034 busy = (state != IDLE).

Reset
REQ-035 AES_rst=1 at an edge (any state, including mid-RUN or mid-OUT): state=IDLE, key_cnt=data_cnt=0.
- Reset values: packing/result regs 0; outputs aes_en=0, aes_data=aes_key=0, m_valid=0, m_data=0, m_last=0, busy=0, err=0.
REQ-036 s_ready=0 while AES_rst=1; err is cleared only by reset.

Verification
REQ-037 Basic block: key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc; data words 0000004b, 0, 0, 0. Bench core raises aes_dout_valid 12 cycles after aes_en with aes_dout=0123456789abcdef_fedcba9876543210.
- aes_en=1 the cycle after the 4th data word.
- aes_key=aa2bdb40bff6a5e8caa9ba3ebc1e2acc and aes_data=0000004b000...0.
- m_data = 01234567, 89abcdef, fedcba98, 76543210; m_last on the last word only.
REQ-038 Key reuse plus sliding window: no new key; send 5 data words a6f2daeb, 140fa720, 529e75d5, 21cbc681, d7b26248.
- RUN starts after the 4th word, so the 5th word is not accepted (s_ready=0).
- aes_data = a6f2daeb140fa720529e75d521cbc681.
- Separate case, data before key: 5 data words sent before any key word -> aes_data holds words 2..5.
REQ-039 Output backpressure: m_ready=0 for 5 cycles on word 2 -> m_data holds 89abcdef, no word is skipped or duplicated.
REQ-040 Timeout with TIMEOUT=64: bench core never responds.
- aes_en is high for exactly 64 cycles, then err=1, busy=0, m_valid never asserts.
- A subsequent block completes normally with err still 1.
REQ-041 Reset mid-RUN at cycle 5 of RUN:
- Next cycle: aes_en=0, busy=0, key_cnt=0.
- A late aes_dout_valid is ignored (no m_valid).
